// File: rtl/dot_matrix_move_ctrl.sv
// dot_matrix_move_ctrl
//   Turns the four raw direction buttons of the 4x4 dot-matrix board into
//   one-hot move commands for the cursor/matrix register block. The buttons
//   are synchronised, debounced and arbitrated, and a held direction
//   auto-repeats.
//
// Ports
//   clk         system clock; all logic runs on posedge
//   reset       asynchronous, active-low; clears all state
//   power       1 = block enabled, 0 = forced OFF
//   up/down/right/left   raw buttons, asynchronous to clk
//   move_ready  matrix accepts the move this cycle
//   move_valid  move command present
//   move_dir    one-hot {left,down,right,up}; 0 when move_valid=0
//   state       FSM state for debug: OFF=0, IDLE=1, ISSUE=2, DELAY=3
module dot_matrix_move_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 8,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic       up,
    input  logic       down,
    input  logic       right,
    input  logic       left,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_dir,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_DELAY = 2'd3
    } state_t;

    state_t st;
    assign state = st;

    // Bit order everywhere: {left, down, right, up}
    logic [3:0]         raw;
    logic [3:0]         sync1, sync2;
    logic [3:0]         db;
    logic [3:0][CW-1:0] deb_cnt;

    assign raw = {left, down, right, up};

    // Two-flop synchroniser and per-button debounce. The counter runs while
    // the synced value disagrees with the debounced one; the debounced bit
    // flips on the edge where the count would reach DEB_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != CW'(DEB_CYCLES)) begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    if (deb_cnt[i] == CW'(DEB_CYCLES - 1))
                        db[i] <= sync2[i];
                end
            end
        end
    end

    // Opposing pairs cancel each other, then fixed priority up>right>down>left.
    logic [3:0] masked;
    logic [3:0] winner;

    always_comb begin
        masked = db;
        if (db[0] && db[2]) begin
            masked[0] = 1'b0;
            masked[2] = 1'b0;
        end
        if (db[1] && db[3]) begin
            masked[1] = 1'b0;
            masked[3] = 1'b0;
        end
        winner = 4'b0000;
        if      (masked[0]) winner = 4'b0001;
        else if (masked[1]) winner = 4'b0010;
        else if (masked[2]) winner = 4'b0100;
        else if (masked[3]) winner = 4'b1000;
    end

    logic [3:0]    dir;
    logic          rep;
    logic [CW-1:0] timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= S_OFF;
            dir        <= '0;
            rep        <= 1'b0;
            timer      <= '0;
            move_valid <= 1'b0;
            move_dir   <= '0;
        end else if (!power) begin
            // Only place a pending command may vanish without a handshake.
            st         <= S_OFF;
            move_valid <= 1'b0;
            move_dir   <= '0;
        end else begin
            case (st)
                S_OFF: begin
                    st <= S_IDLE;
                end
                S_IDLE: begin
                    if (masked != 4'b0000) begin
                        st         <= S_ISSUE;
                        dir        <= winner;
                        rep        <= 1'b0;
                        move_valid <= 1'b1;
                        move_dir   <= winner;
                    end
                end
                S_ISSUE: begin
                    if (move_ready) begin
                        st         <= S_DELAY;
                        timer      <= '0;
                        move_valid <= 1'b0;
                        move_dir   <= '0;
                    end
                end
                S_DELAY: begin
                    // Only the latched direction matters here; other buttons
                    // are ignored until we are back in IDLE.
                    if ((db & dir) == 4'b0000) begin
                        st <= S_IDLE;
                    end else begin
                        if (timer != {CW{1'b1}})
                            timer <= timer + 1'b1;
                        if (!rep && timer == CW'(REP_DELAY - 1)) begin
                            st         <= S_ISSUE;
                            rep        <= 1'b1;
                            move_valid <= 1'b1;
                            move_dir   <= dir;
                        end else if (rep && timer == CW'(REP_PERIOD - 1)) begin
                            st         <= S_ISSUE;
                            move_valid <= 1'b1;
                            move_dir   <= dir;
                        end
                    end
                end
                default: st <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_matrix_move_ctrl.sv
// Directed bench for dot_matrix_move_ctrl with default parameters
// (DEB_CYCLES=4, REP_DELAY=16, REP_PERIOD=8).
module tb_dot_matrix_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       power;
    logic       up, down, right, left;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_dir;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    dot_matrix_move_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .power      (power),
        .up         (up),
        .down       (down),
        .right      (right),
        .left       (left),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (state == 2'd1) break;
            tick();
        end
        check(tag, {6'd0, state}, 8'd1);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] d);
        check({tag, "_valid"}, {7'd0, move_valid}, {7'd0, v});
        check({tag, "_dir"},   {4'd0, move_dir},   {4'd0, d});
    endtask

    initial begin
        logic seen;
        reset = 1'b0; power = 1'b1; move_ready = 1'b1;
        up = 1'b0; down = 1'b0; right = 1'b0; left = 1'b0;

        // 1. reset state, then IDLE one edge after release
        #12;
        check("rst_state", {6'd0, state}, 8'd0);
        check_out("rst", 1'b0, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        check("idle_after_rst", {6'd0, state}, 8'd1);
        check_out("idle", 1'b0, 4'b0000);

        // 2. 3-cycle glitch is filtered; a held press issues after edge 7
        up = 1'b1;
        repeat (3) tick();
        up = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | move_valid;
        end
        check("glitch_no_move", {7'd0, seen}, 8'd0);
        check("glitch_state", {6'd0, state}, 8'd1);
        up = 1'b1;
        repeat (6) tick();
        check_out("up_edge6", 1'b0, 4'b0000);
        tick();
        check_out("up_edge7", 1'b1, 4'b0001);
        tick();
        check_out("up_hs", 1'b0, 4'b0000);
        check("up_delay", {6'd0, state}, 8'd3);
        up = 1'b0;
        wait_idle("up_rel_idle");

        // 3. auto-repeat on right; up added during DELAY is ignored
        right = 1'b1;
        repeat (7) tick();
        check_out("right_first", 1'b1, 4'b0010);
        tick();                                   // handshake H
        check_out("right_hs1", 1'b0, 4'b0000);
        up = 1'b1;
        repeat (15) tick();
        check_out("rep1_early", 1'b0, 4'b0000);
        tick();                                   // H+16
        check_out("rep1", 1'b1, 4'b0010);
        tick();                                   // handshake H2
        repeat (7) tick();
        check_out("rep2_early", 1'b0, 4'b0000);
        tick();                                   // H2+8
        check_out("rep2", 1'b1, 4'b0010);
        tick();                                   // handshake H3
        repeat (7) tick();
        check_out("rep3_early", 1'b0, 4'b0000);
        tick();
        check_out("rep3", 1'b1, 4'b0010);
        right = 1'b0; up = 1'b0;
        wait_idle("right_rel_idle");

        // 4. arbitration
        up = 1'b1; left = 1'b1;
        repeat (7) tick();
        check_out("up_left", 1'b1, 4'b0001);
        up = 1'b0; left = 1'b0;
        wait_idle("ul_idle");
        up = 1'b1; down = 1'b1;
        repeat (12) tick();
        check_out("up_down", 1'b0, 4'b0000);
        check("up_down_state", {6'd0, state}, 8'd1);
        up = 1'b0; down = 1'b0;
        repeat (8) tick();
        up = 1'b1; down = 1'b1; left = 1'b1;
        repeat (7) tick();
        check_out("udl", 1'b1, 4'b1000);
        up = 1'b0; down = 1'b0; left = 1'b0;
        wait_idle("udl_idle");

        // 5. back-pressure holds valid and dir stable
        move_ready = 1'b0;
        down = 1'b1;
        repeat (7) tick();
        check_out("down_issue", 1'b1, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out("down_hold", 1'b1, 4'b0100);
        end
        move_ready = 1'b1;
        tick();
        check("down_accept", {6'd0, state}, 8'd3);
        check_out("down_accept", 1'b0, 4'b0000);
        down = 1'b0;
        wait_idle("down_idle");

        // release during ISSUE: command still completes, then DELAY -> IDLE
        move_ready = 1'b0;
        left = 1'b1;
        repeat (7) tick();
        check_out("left_issue", 1'b1, 4'b1000);
        left = 1'b0;
        repeat (8) tick();
        check_out("left_pending", 1'b1, 4'b1000);
        move_ready = 1'b1;
        tick();
        check("left_delay", {6'd0, state}, 8'd3);
        tick();
        check("left_idle", {6'd0, state}, 8'd1);

        // 6. power drop during ISSUE, debounce state retained
        move_ready = 1'b0;
        up = 1'b1;
        repeat (7) tick();
        check_out("pwr_issue", 1'b1, 4'b0001);
        power = 1'b0;
        tick();
        check("pwr_off_state", {6'd0, state}, 8'd0);
        check_out("pwr_off", 1'b0, 4'b0000);
        power = 1'b1;
        tick();
        check("pwr_on_idle", {6'd0, state}, 8'd1);
        tick();
        check_out("pwr_reissue", 1'b1, 4'b0001);
        move_ready = 1'b1;
        tick();
        repeat (3) tick();
        check("pre_rst_delay", {6'd0, state}, 8'd3);

        // async reset mid-DELAY: outputs clear without a clock edge
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_state", {6'd0, state}, 8'd0);
        check_out("async_rst", 1'b0, 4'b0000);
        up = 1'b0;
        #20;
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
